// File: rtl/regfile_pkg.sv
// ============================================================================
// Module : regfile_pkg
// Brief  : Shared constants and types for the x86 register-snapshot path.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int REGFILE_BEATS = 10;
    localparam int REGFILE_W     = 320;
    localparam int REGFILE_WORD  = 32;

    // Trace order, not the canonical x86 register encoding.
    localparam int TR_EAX    = 0;
    localparam int TR_EBX    = 1;
    localparam int TR_ECX    = 2;
    localparam int TR_EDX    = 3;
    localparam int TR_ESI    = 4;
    localparam int TR_EDI    = 5;
    localparam int TR_ESP    = 6;
    localparam int TR_EBP    = 7;
    localparam int TR_EIP    = 8;
    localparam int TR_EFLAGS = 9;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        PENDING = 1'b1
    } loader_state_e;

endpackage

`default_nettype wire

// File: rtl/regfile_trace_loader.sv
// ============================================================================
// Module : regfile_trace_loader
// Brief  : Builds a 320-bit register snapshot from ten 32-bit trace beats and
//          hands it to the register-file decoder over a valid/ready port.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_trace_loader
    import regfile_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [REGFILE_W-1:0] raw_regs,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [COUNT_W-1:0]   step_count,
    output logic                 frame_err,
    input  logic                 err_clr
);

    localparam logic [0:0] c_COLLECT  = COLLECT;
    localparam logic [0:0] c_PENDING  = PENDING;
    localparam logic [3:0] c_LAST_IDX = 4'(TR_EFLAGS);

    logic [0:0]           r_state;
    logic [3:0]           r_idx;
    logic [REGFILE_W-1:0] r_asm;
    logic [REGFILE_W-1:0] r_raw;
    logic                 r_out_valid;
    logic [COUNT_W-1:0]   r_step;
    logic                 r_err;

    logic w_beat;
    logic w_at_last;
    logic w_good_end;
    logic w_bad_frame;
    logic w_load;

    assign w_beat      = in_valid && (r_state == c_COLLECT);
    assign w_at_last   = (r_idx == c_LAST_IDX);
    assign w_good_end  = w_beat && w_at_last && in_last;
    assign w_bad_frame = w_beat && (in_last != w_at_last);
    assign w_load      = (r_state == c_PENDING) && (!r_out_valid || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_COLLECT;
            r_idx   <= 4'd0;
            r_asm   <= '0;
        end else begin
            case (r_state)
                c_COLLECT: begin
                    if (w_bad_frame) begin
                        // Drop the partial snapshot; the offending beat is consumed.
                        r_idx <= 4'd0;
                        r_asm <= '0;
                    end else if (w_beat) begin
                        r_asm <= {r_asm[REGFILE_W-REGFILE_WORD-1:0], in_data};
                        if (w_good_end) begin
                            r_idx   <= 4'd0;
                            r_state <= c_PENDING;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                c_PENDING: begin
                    if (w_load) r_state <= c_COLLECT;
                end
                default: r_state <= c_COLLECT;
            endcase
        end
    end

    // Reload wins over drain so snapshots can go out back-to-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raw       <= '0;
            r_out_valid <= 1'b0;
            r_step      <= '0;
        end else if (w_load) begin
            r_raw       <= r_asm;
            r_out_valid <= 1'b1;
            r_step      <= r_step + COUNT_W'(1);
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_bad_frame) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign in_ready   = (r_state == c_COLLECT);
    assign raw_regs   = r_raw;
    assign out_valid  = r_out_valid;
    assign step_count = r_step;
    assign frame_err  = r_err;

endmodule

`default_nettype wire
